morse_char_scheduler: RTL

Controller sitting between the UART receiver and the Morse encoder. Completes the receiver's level-held ready/ack handshake, filters and normalises each received byte, buffers accepted characters in a small FIFO, and issues them one at a time to the encoder with a start/done handshake and an optional inter-character gap. Applies backpressure to the receiver by withholding ack while the FIFO is full.

---
 rtl/morse_char_scheduler.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/morse_char_scheduler.sv
// Purpose: receiver-to-Morse-encoder scheduler. Filters and normalises bytes, buffers them, and issues one at a time. Optional CASE_FOLD_EN folds lowercase to uppercase.
// Latency: rx_ready to rx_ack is 3 cycles (2-flop sync plus capture); an empty FIFO issues enc_start 4 cycles after rx_ready.
// Backpressure: rx_ack is withheld while the FIFO is full; the next issue waits for enc_done plus GAP_CYCLES idle cycles.
module morse_char_scheduler #(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    rst_l,
    input  logic                    rx_ready,
    input  logic [7:0]              rx_data,
    output logic                    rx_ack,
    output logic                    enc_start,
    output logic [7:0]              enc_char,
    input  logic                    enc_done,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic [7:0]              drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [15:0] GAP_LOAD = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

    typedef enum logic {
        R_IDLE,
        R_ACK
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_ISSUE,
        T_WAIT,
        T_GAP
    } tx_state_t;

    // Synchronizer and receiver-side state
    logic            r_sync1;
    logic            r_rdy_s;
    rx_state_t       r_rx_state;
    logic            r_rx_ack;
    logic [7:0]      r_drop_cnt;

    // FIFO state
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    // Encoder-side state
    tx_state_t       r_tx_state;
    logic            r_enc_start;
    logic [7:0]      r_enc_char;
    logic [15:0]     r_gap_cnt;

    logic            w_accept;
    logic [7:0]      w_norm;
    logic            w_full;
    logic            w_empty;
    logic            w_rx_take;
    logic            w_push;
    logic            w_pop;
    logic [7:0]      w_head;

    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_rx_take = (r_rx_state == R_IDLE) && r_rdy_s && !w_full;
    assign w_push    = w_rx_take && w_accept;
    // The FIFO is popped in the single T_ISSUE cycle; the head was captured on entry.
    assign w_pop     = (r_tx_state == T_ISSUE);
    assign w_head    = r_mem[r_rd_ptr];

    // Classify the held byte: uppercase, digits and space pass; lowercase only when folded.
    always_comb begin
        w_accept = 1'b0;
        w_norm   = rx_data;
        if ((rx_data >= 8'h41 && rx_data <= 8'h5A) ||
            (rx_data >= 8'h30 && rx_data <= 8'h39) ||
            (rx_data == 8'h20)) begin
            w_accept = 1'b1;
        end
`ifdef CASE_FOLD_EN
        else if (rx_data >= 8'h61 && rx_data <= 8'h7A) begin
            w_accept = 1'b1;
            w_norm   = rx_data - 8'h20;
        end
`endif
    end

    // Two-flop synchronizer for the receiver's level-held ready.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_sync1 <= 1'b0;
            r_rdy_s <= 1'b0;
        end else begin
            r_sync1 <= rx_ready;
            r_rdy_s <= r_sync1;
        end
    end

    // Receiver handshake: capture once per ready assertion, hold ack until ready drops.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_rx_state <= R_IDLE;
            r_rx_ack   <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else begin
            case (r_rx_state)
                R_IDLE: begin
                    if (w_rx_take) begin
                        r_rx_ack   <= 1'b1;
                        r_rx_state <= R_ACK;
                        if (!w_accept && r_drop_cnt != 8'hFF) begin
                            r_drop_cnt <= r_drop_cnt + 8'd1;
                        end
                    end
                end
                R_ACK: begin
                    if (!r_rdy_s) begin
                        r_rx_ack   <= 1'b0;
                        r_rx_state <= R_IDLE;
                    end
                end
                default: r_rx_state <= R_IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care after reset because the pointers clear.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_norm;
        end
    end

    // Encoder sequencing: issue, wait for done, then optional idle gap.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_tx_state  <= T_IDLE;
            r_enc_start <= 1'b0;
            r_enc_char  <= 8'h00;
            r_gap_cnt   <= 16'd0;
        end else begin
            case (r_tx_state)
                T_IDLE: begin
                    if (!w_empty) begin
                        r_tx_state  <= T_ISSUE;
                        r_enc_start <= 1'b1;
                        r_enc_char  <= w_head;
                    end
                end
                T_ISSUE: begin
                    r_enc_start <= 1'b0;
                    r_tx_state  <= T_WAIT;
                end
                T_WAIT: begin
                    if (enc_done) begin
                        if (GAP_CYCLES > 0) begin
                            r_gap_cnt  <= GAP_LOAD;
                            r_tx_state <= T_GAP;
                        end else begin
                            r_tx_state <= T_IDLE;
                        end
                    end
                end
                T_GAP: begin
                    if (r_gap_cnt == 16'd0) begin
                        r_tx_state <= T_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 16'd1;
                    end
                end
                default: r_tx_state <= T_IDLE;
            endcase
        end
    end

    assign rx_ack     = r_rx_ack;
    assign enc_start  = r_enc_start;
    assign enc_char   = r_enc_char;
    assign fifo_count = r_count;
    assign drop_cnt   = r_drop_cnt;

endmodule
